// File: rtl/segre_pkg.sv
// Shared constants and types for the segre memory pipeline.
package segre_pkg;

  localparam int unsigned WORD_SIZE          = 32;
  localparam int unsigned PHYSICAL_ADDR_SIZE = 20;
  localparam int unsigned PAGE_OFFSET_W      = 12;
  localparam int unsigned TLB_VPN_W          = WORD_SIZE - PAGE_OFFSET_W;
  localparam int unsigned TLB_PPN_W          = PHYSICAL_ADDR_SIZE - PAGE_OFFSET_W;

  typedef struct packed {
    logic                 valid;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;

  typedef enum logic {
    TLB_IDLE = 1'b0,
    TLB_WAIT = 1'b1
  } tlb_state_t;

endpackage

// File: rtl/segre_tlb_match.sv
// Combinational CAM compare of a key VPN against every TLB entry.
module segre_tlb_match #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned VPN_W       = 20,
  parameter int unsigned PPN_W       = 8
) (
  input  logic [NUM_ENTRIES-1:0]       valid_i,
  input  logic [NUM_ENTRIES*VPN_W-1:0] vpn_i,
  input  logic [NUM_ENTRIES*PPN_W-1:0] ppn_i,
  input  logic [VPN_W-1:0]             key_i,
  output logic [NUM_ENTRIES-1:0]       match_o,
  output logic                         hit_o,
  output logic [PPN_W-1:0]             ppn_o
);

  logic [NUM_ENTRIES-1:0] match;

  // Per-entry compare; PPN is an OR-select since at most one entry matches.
  always_comb begin
    match = '0;
    ppn_o = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = valid_i[i] && (vpn_i[i*VPN_W +: VPN_W] == key_i);
      if (match[i]) begin
        ppn_o = ppn_o | ppn_i[i*PPN_W +: PPN_W];
      end
    end
    match_o = match;
    hit_o   = |match;
  end

endmodule

// File: rtl/segre_tlb.sv
// Fully associative data TLB with round-robin refill, flush and supervisor bypass.
module segre_tlb
  import segre_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES   = 8,
  parameter int unsigned VADDR_W       = segre_pkg::WORD_SIZE,
  parameter int unsigned PADDR_W       = segre_pkg::PHYSICAL_ADDR_SIZE,
  parameter int unsigned PAGE_OFFSET_W = segre_pkg::PAGE_OFFSET_W
) (
  input  logic                               clock_i,
  input  logic                               rsn_i,
  input  logic                               lookup_valid_i,
  input  logic [VADDR_W-1:0]                 vaddr_i,
  input  logic                               supervisor_i,
  input  logic                               flush_i,
  output logic                               hit_o,
  output logic                               tlbmiss_o,
  output logic [PADDR_W-1:0]                 paddr_o,
  output logic                               miss_req_valid_o,
  output logic [VADDR_W-PAGE_OFFSET_W-1:0]   miss_vpn_o,
  input  logic                               refill_valid_i,
  input  logic [VADDR_W-PAGE_OFFSET_W-1:0]   refill_vpn_i,
  input  logic [PADDR_W-PAGE_OFFSET_W-1:0]   refill_ppn_i
);

  localparam int unsigned VPN_W = VADDR_W - PAGE_OFFSET_W;
  localparam int unsigned PPN_W = PADDR_W - PAGE_OFFSET_W;
  localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]       valid_q;
  logic [NUM_ENTRIES*VPN_W-1:0] vpn_q;
  logic [NUM_ENTRIES*PPN_W-1:0] ppn_q;
  logic [PTR_W-1:0]             ptr_q;

  tlb_state_t       state_q, state_d;
  logic [VPN_W-1:0] miss_vpn_q, miss_vpn_d;
  logic             refill_we;

  logic [VPN_W-1:0]       lk_vpn;
  logic [NUM_ENTRIES-1:0] lk_match, rf_match;
  logic                   lk_hit, rf_hit;
  logic [PPN_W-1:0]       lk_ppn, rf_ppn;

  assign lk_vpn = vaddr_i[VADDR_W-1:PAGE_OFFSET_W];

  segre_tlb_match #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VPN_W       (VPN_W),
    .PPN_W       (PPN_W)
  ) u_lookup_match (
    .valid_i (valid_q),
    .vpn_i   (vpn_q),
    .ppn_i   (ppn_q),
    .key_i   (lk_vpn),
    .match_o (lk_match),
    .hit_o   (lk_hit),
    .ppn_o   (lk_ppn)
  );

  segre_tlb_match #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .VPN_W       (VPN_W),
    .PPN_W       (PPN_W)
  ) u_refill_match (
    .valid_i (valid_q),
    .vpn_i   (vpn_q),
    .ppn_i   (ppn_q),
    .key_i   (refill_vpn_i),
    .match_o (rf_match),
    .hit_o   (rf_hit),
    .ppn_o   (rf_ppn)
  );

  // Zero-latency translation outputs; bypass gives identity mapping.
  always_comb begin
    hit_o     = 1'b0;
    tlbmiss_o = 1'b0;
    paddr_o   = '0;
    if (lookup_valid_i) begin
      if (supervisor_i) begin
        hit_o   = 1'b1;
        paddr_o = vaddr_i[PADDR_W-1:0];
      end else if (lk_hit) begin
        hit_o   = 1'b1;
        paddr_o = {lk_ppn, vaddr_i[PAGE_OFFSET_W-1:0]};
      end else begin
        tlbmiss_o = (lk_match == '0);
      end
    end
  end

  // Miss/refill handshake: one outstanding request; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    miss_vpn_d = miss_vpn_q;
    refill_we  = 1'b0;
    case (state_q)
      TLB_IDLE: begin
        if (tlbmiss_o) begin
          state_d    = TLB_WAIT;
          miss_vpn_d = lk_vpn;
        end
      end
      TLB_WAIT: begin
        if (refill_valid_i) begin
          refill_we = 1'b1;
          state_d   = TLB_IDLE;
        end
      end
      default: state_d = TLB_IDLE;
    endcase
    if (flush_i) begin
      state_d    = TLB_IDLE;
      miss_vpn_d = miss_vpn_q;
      refill_we  = 1'b0;
    end
  end

  // FSM state and requested VPN.
  always_ff @(posedge clock_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= TLB_IDLE;
      miss_vpn_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_vpn_q <= miss_vpn_d;
    end
  end

  assign miss_req_valid_o = (state_q == TLB_WAIT);
  assign miss_vpn_o       = miss_vpn_q;

  // Entry storage: duplicate VPN updates in place, otherwise fill the victim slot.
  always_ff @(posedge clock_i or negedge rsn_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
      vpn_q   <= '0;
      ppn_q   <= '0;
      ptr_q   <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (refill_we) begin
      if (rf_hit) begin
        if (rf_ppn != refill_ppn_i) begin
          for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (rf_match[i]) begin
              ppn_q[i*PPN_W +: PPN_W] <= refill_ppn_i;
            end
          end
        end
      end else begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
          if (ptr_q == PTR_W'(i)) begin
            valid_q[i]              <= 1'b1;
            vpn_q[i*VPN_W +: VPN_W] <= refill_vpn_i;
            ppn_q[i*PPN_W +: PPN_W] <= refill_ppn_i;
          end
        end
        ptr_q <= ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: doc/segre_tlb.md
# segre_tlb

Parametrised, fully associative translation lookaside buffer replacing the fixed 32-entry direct-mapped data TLB. It sits between the memory stage and the data cache, translating virtual addresses to physical addresses combinationally on a hit. On a miss it raises a registered refill request that the page-table walker answers. It also adds round-robin replacement, flush, and a supervisor bypass mode.

## Interface
- NUM_ENTRIES, 8, number of entries; power of two, ≥2
- VADDR_W, WORD_SIZE, virtual address width
- PADDR_W, PHYSICAL_ADDR_SIZE, physical address width
- PAGE_OFFSET_W, 12, page offset bits (4 KB pages); VPN_W = VADDR_W-PAGE_OFFSET_W, PPN_W = PADDR_W-PAGE_OFFSET_W
- clock_i  in  1  clock
- rsn_i  in  1  reset; asynchronous, active-low
- lookup_valid_i  in  1  vaddr_i carries a translation request this cycle
- vaddr_i  in  VADDR_W  virtual address
- supervisor_i  in  1  bypass mode; identity translation
- flush_i  in  1  invalidate all entries and drop any pending miss
- hit_o  out  1  translation valid this cycle
- tlbmiss_o  out  1  lookup missed this cycle
- paddr_o  out  PADDR_W  physical address
- miss_req_valid_o  out  1  refill request pending (registered)
- miss_vpn_o  out  VPN_W  VPN being requested (registered)
- refill_valid_i  in  1  refill data valid
- refill_vpn_i  in  VPN_W  refill VPN
- refill_ppn_i  in  PPN_W  refill PPN

## Operation
- Storage: NUM_ENTRIES registers {valid, vpn, ppn} and a victim pointer of $clog2(NUM_ENTRIES) bits.
- Lookup is combinational over registered contents. Match condition: valid && vpn == vaddr_i[VADDR_W-1:PAGE_OFFSET_W].
  - Match: hit_o=1 and paddr_o={ppn, vaddr_i[PAGE_OFFSET_W-1:0]}.
  - Multiple matches cannot occur (see refill rule).
- lookup_valid_i=0: hit_o=0, tlbmiss_o=0, paddr_o=0.
- supervisor_i=1 with lookup_valid_i=1: hit_o=1, tlbmiss_o=0, paddr_o=vaddr_i[PADDR_W-1:0]. No miss is raised and entries are untouched.
- Miss: lookup_valid_i=1, supervisor_i=0, no match. tlbmiss_o=1.
- FSM states:
  - IDLE: a miss loads miss_vpn_o with the VPN and moves to WAIT.
  - WAIT: miss_req_valid_o=1. Lookups still served; hits return normally. Misses assert tlbmiss_o but issue no new request and do not change miss_vpn_o. refill_valid_i=1 writes the entry and returns to IDLE.
- Refill write:
  - If refill_vpn_i matches a valid entry, that entry's ppn is overwritten and the pointer does not move.
  - Otherwise the entry at the pointer is written valid and the pointer increments, wrapping at NUM_ENTRIES-1 to 0.
  - refill_vpn_i is not checked against miss_vpn_o.
  - refill_valid_i in IDLE is ignored.
- flush_i clears all valid bits, resets the pointer to 0 and forces IDLE.
  - flush_i has priority over a same-cycle refill, which is discarded, and over a same-cycle miss, which starts no request.
  - tlbmiss_o/hit_o in the flush cycle reflect pre-flush contents.

## Timing
- Reset values: all valid=0, pointer=0, state IDLE, miss_req_valid_o=0, miss_vpn_o=0. Combinational outputs are as for lookup_valid_i=0.
- hit_o/tlbmiss_o/paddr_o: zero-cycle latency from vaddr_i.
- miss_req_valid_o rises the cycle after the first missing lookup. It stays high until the cycle after the refill (or flush) is accepted.
- A refill entry becomes visible to lookups the cycle after refill_valid_i. A same-cycle lookup of that VPN still misses.
- Minimum miss-to-hit turnaround is 2 cycles (miss, refill, hit).
- Reset mid-WAIT: immediate return to reset values; a later refill_valid_i is ignored.

## Structure
- segre_pkg gains:
  - PAGE_OFFSET_W constant
  - tlb_entry_t packed struct {valid, vpn, ppn}, sized by package defaults
  - tlb_state_t enum {TLB_IDLE, TLB_WAIT}
- Sub-module segre_tlb_match: combinational CAM compare. Outputs a one-hot match vector, a hit flag and the selected PPN. Reused for both the lookup port and the refill duplicate check (two instances).

## Test plan
- Reset, lookup 0x00003ABC → tlbmiss_o=1, hit_o=0. Next cycle miss_req_valid_o=1, miss_vpn_o=0x00003.
- In WAIT, refill vpn 0x00003 ppn 0x5A → next cycle miss_req_valid_o=0. Lookup 0x00003ABC → hit_o=1, paddr_o=0x5AABC.
- NUM_ENTRIES=4: refill VPNs 1..5 in turn → VPN 1 misses, VPNs 2..5 hit. Then refill VPN 3 with new PPN 0x77 → 0x00003010 → 0x77010, and VPN 2 still hits (pointer not advanced).
- supervisor_i=1, vaddr 0xDEADBEEF with an empty TLB → hit_o=1, paddr_o=0xDBEEF, no request raised.
- In WAIT, flush_i and refill_valid_i in the same cycle → next cycle miss_req_valid_o=0, every previously valid VPN misses, and the refilled VPN is absent.
- In WAIT, lookup of a second unmapped VPN 0x00009 → tlbmiss_o=1, miss_vpn_o remains 0x00003.
